phy_rx_lane_ctrl: RTL and testbench
===================================

# phy_rx_lane_ctrl

Receive-side lane controller for the two-lane serial PHY. It runs on `clk_32f` and takes the per-lane deserialized bytes with their one-cycle valid strobes. It runs a comma-based (BC) synchronization state machine per lane and buffers each active lane's data bytes in a small FIFO. It then merges both lanes into a single tagged byte stream through a round-robin arbiter, which feeds the word assembler that produces the 32-bit `salida` output.

## Interface
- BC_CODE, 8'hBC: comma/idle symbol.
- SYNC_COUNT, 4: consecutive BC bytes required to declare a lane active (legal range 1..7).
- FIFO_DEPTH, 4: per-lane FIFO entries (power of 2, ≥2).

- clk_32f  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- lane_en  in  2  per-lane enable; bit i controls lane i.
- byte_0  in  8  lane 0 deserialized byte.
- byte_valid_0  in  1  one-cycle strobe, byte_0 valid; at most once per 8 cycles.
- byte_1  in  8  lane 1 deserialized byte.
- byte_valid_1  in  1  one-cycle strobe, byte_1 valid; at most once per 8 cycles.
- data_out  out  8  merged data byte; 0 when valid_out=0.
- valid_out  out  1  data_out/lane_id valid this cycle.
- lane_id  out  1  source lane of data_out; 0 when valid_out=0.
- active  out  2  bit i = lane i in ACTIVE.
- overflow  out  2  sticky; bit i = lane i dropped a byte on a full FIFO.

## Operation
- Per-lane FSM, 3 states: IDLE, SEARCH, ACTIVE. Counter bc_cnt is 3 bits wide.
  - IDLE: bc_cnt=0 and FIFO empty. If lane_en[i]=1, the next state is SEARCH.
  - SEARCH: a valid BC byte increments bc_cnt. A valid non-BC byte clears bc_cnt to 0. When the valid byte that makes the count equal SYNC_COUNT arrives, the next state is ACTIVE and bc_cnt is cleared. Bytes received in SEARCH are never stored.
  - ACTIVE: a valid non-BC byte is pushed into the lane FIFO. A valid BC byte is discarded as idle.
  - In any state, lane_en[i]=0 forces IDLE on the next edge. In the same edge, bc_cnt is cleared and the FIFO is flushed by resetting its pointers. Bytes presented in that cycle are discarded.
- active[i] is registered and equals (state_i==ACTIVE).
- FIFO, one per lane:
  - Push when full and no pop in the same cycle: the byte is dropped and overflow[i] is set. overflow[i] clears only on reset.
  - Push and pop in the same cycle when full: the push is accepted and overflow is not set.
  - The pop decision uses the occupancy before the edge. A byte pushed in cycle t is never popped in cycle t.
- Arbiter:
  - Each cycle, if any FIFO is non-empty, exactly one byte is popped.
  - If only one FIFO is non-empty, that lane is granted.
  - If both are non-empty, the lane ≠ last_grant is granted.
  - last_grant updates only on a grant. Its reset value is 1, so lane 0 wins the first tie.
- Output register: the granted byte and lane index load into data_out/lane_id with valid_out=1. With no grant, valid_out=0 and data_out and lane_id are 0.
- Reset (synchronous, priority over everything):
  - All FSMs go to IDLE; bc_cnt=0; FIFOs are empty.
  - last_grant=1.
  - Outputs: data_out=0, valid_out=0, lane_id=0, active=2'b00, overflow=2'b00.

## Timing
- Reset asserted at edge E: all outputs are at reset values after E.
- First reset-free edge with lane_en[i]=1: IDLE→SEARCH.
- Sync: the SYNC_COUNT-th consecutive BC strobe is sampled at edge E. State is ACTIVE and active[i]=1 after E. The next valid byte is treated as ACTIVE.
- Data latency: a data byte whose strobe is sampled at edge E is pushed at E. With no contention, it appears on data_out with valid_out=1 after edge E+1 (2-cycle strobe-to-output).
- Contention: both lanes push at the same edge E. The first byte is output after E+1 and the second after E+2, in alternating order.
- Sustained throughput: 1 byte/cycle out, against at most 2 bytes per 8 cycles in. FIFOs overflow only under a malformed strobe rate.
- lane_en deassert sampled at edge E: active[i]=0 after E, and that lane's bytes stop appearing from E+1 onward. The output register may still show one byte popped at E.

## Test plan
- Reset and sync:
  - Stimulus: reset for 2 cycles, lane_en=2'b01, lane 0 strobes BC,BC,BC,BC every 8 cycles.
  - Response: active=2'b00 until the 4th BC edge, then 2'b01. No valid_out throughout. active[1] stays 0.
- Sync break:
  - Stimulus: lane 0 sends BC,BC,BC,8'h55,BC,BC,BC,BC.
  - Response: active[0] rises only after the 8th strobe. 8'h55 is never output.
- Data and idle filtering:
  - Stimulus: lane 0 active, then sends 8'hA1,BC,8'hA2.
  - Response: data_out=8'hA1 then 8'hA2 with lane_id=0, each 2 cycles after its strobe. No output for BC.
- Round-robin:
  - Stimulus: both lanes active, with simultaneous strobes lane0=8'h10/8'h11 and lane1=8'h20/8'h21.
  - Response: output sequence 10(l0),20(l1), then on the second round 11(l0),21(l1), each pair on consecutive cycles.
- Overflow:
  - Stimulus: lane 1 active, strobe every cycle with bytes 1..9 while lane 0 is idle.
  - Response: all bytes output in order. The pop rate keeps pace and overflow stays 2'b00.
  - Variant: a bench-forced 5-entry burst with a pop hold. The 5th byte is dropped and overflow[1]=1 until reset.
- Disable mid-stream:
  - Stimulus: lane_en[0]→0 with 2 bytes buffered.
  - Response: active[0]=0 next cycle, and the buffered bytes are flushed and never output.
  - Follow-up: re-enable lane_en[0]. Lane 0 requires 4 new BC bytes before any data is output.

Source files
------------

// File: rtl/phy_rx_lane_ctrl.sv
// Two-lane receive controller: per-lane comma sync FSM and byte FIFO.
// A round-robin merge drives a single tagged byte stream out.
module phy_rx_lane_ctrl #(
    parameter logic [7:0]  BC_CODE    = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [1:0] lane_en,
    input  logic [7:0] byte_0,
    input  logic       byte_valid_0,
    input  logic [7:0] byte_1,
    input  logic       byte_valid_1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_id,
    output logic [1:0] active,
    output logic [1:0] overflow
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned NUM_LANES = 2;
    localparam logic [2:0]  SYNC_LAST = 3'(SYNC_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_ACTIVE = 2'd2
    } lane_state_t;

    logic [1:0][7:0] bytes_in;
    logic [1:0]      vld_in;
    logic [1:0][7:0] head;
    logic [1:0]      not_empty;
    logic [1:0]      pop;
    logic            grant_any;
    logic            grant_lane;
    logic            last_grant_q;

    assign bytes_in = {byte_1, byte_0};
    assign vld_in   = {byte_valid_1, byte_valid_0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_state_t    state_q, state_d;
        logic [2:0]     bc_cnt_q, bc_cnt_d;
        logic [7:0]     mem_q [FIFO_DEPTH];
        logic [PTR_W:0] wr_ptr_q, rd_ptr_q, fill;
        logic           is_bc, push, full, accept, drop;
        logic           active_q, overflow_q;

        assign is_bc        = (bytes_in[g] == BC_CODE);
        assign fill         = wr_ptr_q - rd_ptr_q;
        assign full         = fill[PTR_W];
        assign not_empty[g] = (fill != '0);
        assign head[g]      = mem_q[rd_ptr_q[PTR_W-1:0]];
        // A full FIFO still takes a byte when the arbiter drains it this cycle.
        assign accept       = push && (!full || pop[g]);
        assign drop         = push && full && !pop[g];
        assign active[g]    = active_q;
        assign overflow[g]  = overflow_q;

        always_ff @(posedge clk_32f) begin : state_reg
            if (reset) begin
                state_q  <= ST_IDLE;
                bc_cnt_q <= '0;
            end else begin
                state_q  <= state_d;
                bc_cnt_q <= bc_cnt_d;
            end
        end

        // Comma hunt: SYNC_COUNT back-to-back BC strobes lock the lane.
        always_comb begin : state_next
            state_d  = state_q;
            bc_cnt_d = bc_cnt_q;
            push     = 1'b0;
            if (!lane_en[g]) begin
                state_d  = ST_IDLE;
                bc_cnt_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_SEARCH;
                    ST_SEARCH: begin
                        if (vld_in[g]) begin
                            if (!is_bc) begin
                                bc_cnt_d = '0;
                            end else if (bc_cnt_q == SYNC_LAST) begin
                                state_d  = ST_ACTIVE;
                                bc_cnt_d = '0;
                            end else begin
                                bc_cnt_d = bc_cnt_q + 3'd1;
                            end
                        end
                    end
                    ST_ACTIVE: push = vld_in[g] && !is_bc;
                    default:   state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk_32f) begin : fifo_ctrl
            if (reset) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                active_q   <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                active_q <= (state_d == ST_ACTIVE);
                if (!lane_en[g]) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (pop[g]) rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (drop) overflow_q <= 1'b1;
            end
        end

        always_ff @(posedge clk_32f) begin : fifo_mem
            if (accept) mem_q[wr_ptr_q[PTR_W-1:0]] <= bytes_in[g];
        end
    end

    // On a tie the lane that did not win last time is served.
    assign grant_any  = |not_empty;
    assign grant_lane = (&not_empty) ? ~last_grant_q : not_empty[1];
    assign pop        = grant_any ? (grant_lane ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_32f) begin : out_reg
        if (reset) begin
            data_out     <= '0;
            valid_out    <= 1'b0;
            lane_id      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            valid_out <= grant_any;
            data_out  <= grant_any ? head[grant_lane] : 8'h00;
            lane_id   <= grant_any & grant_lane;
            if (grant_any) last_grant_q <= grant_lane;
        end
    end

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Bench for phy_rx_lane_ctrl: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_phy_rx_lane_ctrl;

    localparam logic [7:0] BC    = 8'hBC;
    localparam int         SYNC  = 4;
    localparam int         DEPTH = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [1:0] lane_en;
    logic [7:0] byte_0, byte_1;
    logic       byte_valid_0, byte_valid_1;
    logic [7:0] data_out;
    logic       valid_out, lane_id;
    logic [1:0] active, overflow;

    always #5 clk_32f = ~clk_32f;

    phy_rx_lane_ctrl #(
        .BC_CODE   (BC),
        .SYNC_COUNT(SYNC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .lane_en     (lane_en),
        .byte_0      (byte_0),
        .byte_valid_0(byte_valid_0),
        .byte_1      (byte_1),
        .byte_valid_1(byte_valid_1),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_id     (lane_id),
        .active      (active),
        .overflow    (overflow)
    );

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic       v0;
        logic [7:0] b0;
        logic       v1;
        logic [7:0] b1;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [1:0] ea;
        logic [1:0] eo;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    logic [8:0] seen_q[$];
    int         seen_cyc[$];

    // Reference model: each lane is "awake", "locked", a BC run length and a byte queue.
    bit         m_awake[2];
    bit         m_lock[2];
    int         m_run[2];
    logic [7:0] m_q[2][$];
    bit         m_last;
    logic [1:0] m_ovf;
    logic       m_vld;
    logic [7:0] m_data;
    logic       m_lane;

    logic [8:0] rr_exp[4];
    logic [7:0] sb[8];
    logic [1:0] en_r;
    int         n0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] en, input logic [1:0] v,
                              input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] b[2];
        int g;
        b[0] = b0;
        b[1] = b1;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_q[i].delete();
                m_awake[i] = 0;
                m_lock[i]  = 0;
                m_run[i]   = 0;
            end
            m_last = 1;
            m_ovf  = 2'b00;
            m_vld  = 0;
            m_data = 8'h00;
            m_lane = 0;
            return;
        end
        if (m_q[0].size() > 0 || m_q[1].size() > 0) begin
            if (m_q[0].size() > 0 && m_q[1].size() > 0) g = m_last ? 0 : 1;
            else g = (m_q[1].size() > 0) ? 1 : 0;
            m_data = m_q[g].pop_front();
            m_vld  = 1;
            m_lane = 1'(g);
            m_last = (g == 1);
        end else begin
            m_vld  = 0;
            m_data = 8'h00;
            m_lane = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!en[i]) begin
                m_q[i].delete();
                m_awake[i] = 0;
                m_lock[i]  = 0;
                m_run[i]   = 0;
            end else if (!m_awake[i]) begin
                m_awake[i] = 1;
            end else if (!m_lock[i]) begin
                if (v[i]) begin
                    if (b[i] == BC) begin
                        m_run[i]++;
                        if (m_run[i] == SYNC) begin
                            m_lock[i] = 1;
                            m_run[i]  = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end else if (v[i] && b[i] != BC) begin
                if (m_q[i].size() < DEPTH) m_q[i].push_back(b[i]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] en, input logic v0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] b1);
        reset        = r;
        lane_en      = en;
        byte_valid_0 = v0;
        byte_0       = b0;
        byte_valid_1 = v1;
        byte_1       = b1;
        @(posedge clk_32f);
        model_step(r, en, {v1, v0}, b0, b1);
        cyc_n++;
        #1;
        chk("model", {18'b0, valid_out, data_out, lane_id, active, overflow},
            {18'b0, m_vld, m_data, m_lane, m_lock[1], m_lock[0], m_ovf});
        if (valid_out) begin
            seen_q.push_back({lane_id, data_out});
            seen_cyc.push_back(cyc_n);
        end
    endtask

    task automatic idle(input int n, input logic [1:0] en);
        repeat (n) cyc(1'b0, en, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic add(input logic r, input logic [1:0] en, input logic v0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] b1, input logic ev, input logic [7:0] ed,
                       input logic el, input logic [1:0] ea, input logic [1:0] eo);
        vec_t v;
        v.rst = r;  v.en = en; v.v0 = v0; v.b0 = b0; v.v1 = v1; v.b1 = b1;
        v.ev = ev;  v.ed = ed; v.el = el; v.ea = ea; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic seen_clear();
        seen_q.delete();
        seen_cyc.delete();
    endtask

    initial begin
        reset = 1'b1; lane_en = 2'b00;
        byte_0 = 8'h00; byte_1 = 8'h00; byte_valid_0 = 1'b0; byte_valid_1 = 1'b0;

        // Reset, lane 0 sync on BC every 8 cycles, then data/idle filtering.
        repeat (2) add(1, 2'b00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 2'b00, 2'b00);
        add(0, 2'b01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) begin
            add(0, 2'b01, 1, BC, 0, 8'h00, 0, 8'h00, 0, 2'(k == 3), 2'b00);
            repeat (7) add(0, 2'b01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 2'(k == 3), 2'b00);
        end
        add(0, 2'b01, 1, 8'hA1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 2'b00);
        add(0, 2'b01, 0, 8'h00, 0, 8'h00, 1, 8'hA1, 0, 2'b01, 2'b00);
        repeat (6) add(0, 2'b01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 2'b01, 2'b00);
        add(0, 2'b01, 1, BC, 0, 8'h00, 0, 8'h00, 0, 2'b01, 2'b00);
        repeat (7) add(0, 2'b01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 2'b01, 2'b00);
        add(0, 2'b01, 1, 8'hA2, 0, 8'h00, 0, 8'h00, 0, 2'b01, 2'b00);
        add(0, 2'b01, 0, 8'h00, 0, 8'h00, 1, 8'hA2, 0, 2'b01, 2'b00);
        repeat (2) add(0, 2'b01, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 2'b01, 2'b00);

        foreach (tbl[k]) begin
            cyc(tbl[k].rst, tbl[k].en, tbl[k].v0, tbl[k].b0, tbl[k].v1, tbl[k].b1);
            chk("table", {18'b0, valid_out, data_out, lane_id, active, overflow},
                {18'b0, tbl[k].ev, tbl[k].ed, tbl[k].el, tbl[k].ea, tbl[k].eo});
        end

        // Round-robin: bring lane 1 up, give it one byte so lane 0 wins the next tie.
        idle(1, 2'b11);
        repeat (4) cyc(1'b0, 2'b11, 1'b0, 8'h00, 1'b1, BC);
        chk("rr_active", 32'(active), 32'h3);
        cyc(1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 8'h2F);
        idle(2, 2'b11);
        seen_clear();
        cyc(1'b0, 2'b11, 1'b1, 8'h10, 1'b1, 8'h20);
        idle(7, 2'b11);
        cyc(1'b0, 2'b11, 1'b1, 8'h11, 1'b1, 8'h21);
        idle(7, 2'b11);
        rr_exp[0] = 9'h010; rr_exp[1] = 9'h120; rr_exp[2] = 9'h011; rr_exp[3] = 9'h121;
        chk("rr_count", 32'(seen_q.size()), 32'd4);
        if (seen_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("rr_order", 32'(seen_q[k]), 32'(rr_exp[k]));
            chk("rr_pair0", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);
            chk("rr_pair1", 32'(seen_cyc[3] - seen_cyc[2]), 32'd1);
        end

        // Back-to-back strobes on lane 1 alone: the pop rate keeps up.
        seen_clear();
        for (int k = 1; k <= 9; k++) cyc(1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 8'(k));
        idle(3, 2'b11);
        chk("tp_count", 32'(seen_q.size()), 32'd9);
        if (seen_q.size() == 9)
            for (int k = 0; k < 9; k++) chk("tp_order", 32'(seen_q[k]), 32'h100 + 32'(k + 1));
        chk("tp_ovf", 32'(overflow), 32'h0);

        // Both lanes flooding: each is served every other cycle, so both overflow.
        for (int k = 0; k < 12; k++) cyc(1'b0, 2'b11, 1'b1, 8'(8'h40 + k), 1'b1, 8'(8'h60 + k));
        chk("ovf_set", 32'(overflow[1]), 32'h1);
        idle(14, 2'b11);
        chk("ovf_sticky", 32'(overflow[1]), 32'h1);
        repeat (2) cyc(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("ovf_clear", 32'(overflow), 32'h0);

        // Disable lane 0 with a backlog queued behind lane 1 traffic.
        idle(1, 2'b11);
        repeat (4) cyc(1'b0, 2'b11, 1'b1, BC, 1'b1, BC);
        chk("dis_sync", 32'(active), 32'h3);
        for (int k = 0; k < 3; k++) cyc(1'b0, 2'b11, 1'b1, 8'(8'h30 + k), 1'b1, 8'(8'h50 + k));
        cyc(1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("dis_active", 32'(active[0]), 32'h0);
        seen_clear();
        idle(6, 2'b10);
        n0 = 0;
        foreach (seen_q[k]) if (seen_q[k][8] == 1'b0) n0++;
        chk("dis_flush", 32'(n0), 32'd0);

        // Re-enable with a broken comma run: only the final four BCs count.
        seen_clear();
        idle(1, 2'b11);
        sb[0] = BC; sb[1] = BC; sb[2] = BC; sb[3] = 8'h55;
        sb[4] = BC; sb[5] = BC; sb[6] = BC; sb[7] = BC;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 2'b11, 1'b1, sb[k], 1'b0, 8'h00);
            chk("sb_active", 32'(active[0]), 32'(k == 7));
            idle(1, 2'b11);
        end
        cyc(1'b0, 2'b11, 1'b1, 8'h99, 1'b0, 8'h00);
        idle(3, 2'b11);
        chk("sb_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() == 1) chk("sb_data", 32'(seen_q[0]), 32'h099);

        // Random traffic with occasional enable flips and resets.
        en_r = 2'b11;
        for (int k = 0; k < 3000; k++) begin
            logic r, v0, v1;
            logic [7:0] b0, b1;
            if ($urandom_range(0, 99) == 0) en_r = en_r ^ 2'(1 << $urandom_range(0, 1));
            r  = ($urandom_range(0, 799) == 0);
            v0 = ($urandom_range(0, 2) == 0);
            v1 = ($urandom_range(0, 2) == 0);
            b0 = ($urandom_range(0, 1) == 1) ? BC : 8'($urandom);
            b1 = ($urandom_range(0, 1) == 1) ? BC : 8'($urandom);
            cyc(r, en_r, v0, b0, v1, b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
